// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//
// Purpose:
//   Immediate generator with a small elastic output buffer. Each accepted
//   request carries a 32-bit instruction word and a format code. The block
//   pulls out the immediate field for that format and sign- or
//   zero-extends it to XLEN. It then queues the result in a DEPTH-entry
//   FIFO. The consumer drains the FIFO through a valid/ready handshake.
//
// Parameters:
//   XLEN   - width of the extended immediate (32 or 64)
//   DEPTH  - number of output buffer entries (2..8)
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   request valid
//   in_ready     out  request accepted this cycle when in_valid is also 1
//   in_instr     in   32-bit instruction word
//   in_fmt       in   0=I 1=S 2=B 3=U 4=J 5=Z(CSR zimm) 6/7=illegal
//   in_unsigned  in   zero-extend instead of sign-extend
//   out_valid    out  buffer head holds a result
//   out_ready    in   consumer takes the head this cycle
//   out_imm      out  extended immediate at the buffer head
//   out_err      out  head entry came from an illegal format code
//   count        out  current buffer occupancy
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_fmt,
    input  logic            in_unsigned,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic            out_err,
    output logic [CW-1:0]   count
);

    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_S   = 3'd1,
        FMT_B   = 3'd2,
        FMT_U   = 3'd3,
        FMT_J   = 3'd4,
        FMT_Z   = 3'd5,
        FMT_BAD6 = 3'd6,
        FMT_BAD7 = 3'd7
    } fmt_t;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [XLEN-1:0] mem_imm [DEPTH];
    logic            mem_err [DEPTH];

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    logic [XLEN-1:0] new_imm;
    logic            new_err;
    logic            ext_fill;
    logic            push;
    logic            pop;

    // Every signed format keeps its field MSB in instr[31], so one fill bit
    // covers I, S, B, U and J. Z is handled separately because it is always
    // zero-extended.
    assign ext_fill = ~in_unsigned & in_instr[31];

    // Start from a fully filled word and then overwrite the low bits with
    // the raw field. The upper bits then already hold the extension.
    always_comb begin
        new_imm = {XLEN{ext_fill}};
        new_err = 1'b0;
        case (fmt_t'(in_fmt))
            FMT_I: new_imm[11:0] = in_instr[31:20];
            FMT_S: new_imm[11:0] = {in_instr[31:25], in_instr[11:7]};
            FMT_B: new_imm[12:0] = {in_instr[31], in_instr[7],
                                    in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: new_imm[31:0] = {in_instr[31:12], 12'b0};
            FMT_J: new_imm[20:0] = {in_instr[31], in_instr[19:12],
                                    in_instr[20], in_instr[30:21], 1'b0};
            FMT_Z: begin
                new_imm      = '0;
                new_imm[4:0] = in_instr[19:15];
            end
            default: begin
                new_imm = '0;
                new_err = 1'b1;
            end
        endcase
    end

    // While full, a request can still go in because the concurrent pop
    // frees a slot at the same edge. Ready is held low during reset.
    assign in_ready  = rst_n & ((count < DEPTH_C) | out_ready);
    assign push      = in_valid & in_ready;
    assign pop       = out_ready & (count != '0);
    assign out_valid = (count != '0);

    // Buffer storage is deliberately left out of the reset path. The head
    // is gated by out_valid so stale contents never reach the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_imm[wr_ptr] <= new_imm;
            mem_err[wr_ptr] <= new_err;
        end
    end

    assign out_imm = out_valid ? mem_imm[rd_ptr] : '0;
    assign out_err = out_valid ? mem_err[rd_ptr] : 1'b0;

    // The pointers wrap at DEPTH-1 explicitly so that DEPTH values which
    // are not a power of two still behave as a true circular buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Purpose:
//   Scoreboard bench for imm_gen_pipe. Two instances share one stimulus
//   stream: one with XLEN=32 and one with XLEN=64, both with DEPTH=2.
//   applyStimulus pushes the hand-computed result for each width into a
//   queue at the point the request is accepted. A monitor compares the
//   buffer head against the queue front on every falling edge and pops the
//   entry when the consumer takes it.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_fmt;
    logic        in_unsigned;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_imm32;
    logic [1:0]  count32;

    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_imm64;
    logic [1:0]  count64;

    exp_t q32[$];
    exp_t q64[$];

    int total = 0;
    int bad   = 0;

    bit c_done;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready32),
        .in_instr   (in_instr),
        .in_fmt     (in_fmt),
        .in_unsigned(in_unsigned),
        .out_valid  (out_valid32),
        .out_ready  (out_ready),
        .out_imm    (out_imm32),
        .out_err    (out_err32),
        .count      (count32)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut64 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready64),
        .in_instr   (in_instr),
        .in_fmt     (in_fmt),
        .in_unsigned(in_unsigned),
        .out_valid  (out_valid64),
        .out_ready  (out_ready),
        .out_imm    (out_imm64),
        .out_err    (out_err64),
        .count      (count64)
    );

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Hold the request until both instances accept it. Push the
    // expectations at the falling edge before the accepting rising edge.
    // The inputs are scrambled afterwards with in_valid low, so that any
    // capture of an invalid request shows up as an unexpected entry.
    task automatic applyStimulus(input logic [31:0] instr,
                                 input logic [2:0]  fmt,
                                 input logic        uns,
                                 input logic [31:0] e32,
                                 input logic [63:0] e64,
                                 input logic        err);
        int   waited = 0;
        bit   ok = 1'b0;
        exp_t e;
        in_instr    = instr;
        in_fmt      = fmt;
        in_unsigned = uns;
        in_valid    = 1'b1;
        while (!ok && waited < 50) begin
            @(negedge clk);
            if (in_ready32 && in_ready64) begin
                e.imm = {32'b0, e32};
                e.err = err;
                q32.push_back(e);
                e.imm = e64;
                q64.push_back(e);
                ok = 1'b1;
            end else begin
                waited++;
            end
        end
        if (!ok) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in_instr    = $urandom;
        in_fmt      = 3'd7;
        in_unsigned = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 64'(q32.size() + q64.size()), 64'd0);
    endtask

    // Scoreboard monitor: the head must match the oldest expectation on
    // every falling edge while valid, which also covers stability under
    // backpressure. A valid head with no expectation pending is a stale
    // or spurious entry.
    always @(negedge clk) begin
        if (rst_n && out_valid32) begin
            if (q32.size() == 0) begin
                checkOutput("stale32", 64'd1, 64'd0);
            end else begin
                checkOutput("imm32", {32'b0, out_imm32}, q32[0].imm);
                checkOutput("err32", 64'(out_err32), 64'(q32[0].err));
                if (out_ready) q32.delete(0);
            end
        end
        if (rst_n && out_valid64) begin
            if (q64.size() == 0) begin
                checkOutput("stale64", 64'd1, 64'd0);
            end else begin
                checkOutput("imm64", out_imm64, q64[0].imm);
                checkOutput("err64", 64'(out_err64), 64'(q64[0].err));
                if (out_ready) q64.delete(0);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_instr    = 32'h0;
        in_fmt      = 3'd0;
        in_unsigned = 1'b0;
        out_ready   = 1'b1;
        c_done      = 1'b0;

        // Reset state, before any clock edge has occurred
        #1;
        checkOutput("rst_in_ready",  64'(in_ready32),  64'd0);
        checkOutput("rst_out_valid", 64'(out_valid32), 64'd0);
        checkOutput("rst_count",     64'(count32),     64'd0);
        checkOutput("rst_out_imm",   {32'b0, out_imm32}, 64'd0);
        checkOutput("rst_out_err",   64'(out_err32),   64'd0);
        checkOutput("rst_out_imm64", out_imm64,        64'd0);
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_in_ready", 64'(in_ready32), 64'd1);

        // I-format signed, checked for a latency of one cycle
        applyStimulus(32'hFFF00093, 3'd0, 1'b0, 32'hFFFFFFFF,
                      64'hFFFFFFFFFFFFFFFF, 1'b0);
        checkOutput("lat1_valid", 64'(out_valid32), 64'd1);
        checkOutput("lat1_count", 64'(count32),     64'd1);
        applyStimulus(32'hFFF00093, 3'd0, 1'b1, 32'h00000FFF,
                      64'h0000000000000FFF, 1'b0);
        applyStimulus(32'hFE0000A3, 3'd1, 1'b0, 32'hFFFFFFE1,
                      64'hFFFFFFFFFFFFFFE1, 1'b0);
        applyStimulus(32'h80000063, 3'd2, 1'b0, 32'hFFFFF000,
                      64'hFFFFFFFFFFFFF000, 1'b0);
        applyStimulus(32'h0010006F, 3'd4, 1'b0, 32'h00000800,
                      64'h0000000000000800, 1'b0);
        applyStimulus(32'h800002B7, 3'd3, 1'b0, 32'h80000000,
                      64'hFFFFFFFF80000000, 1'b0);
        applyStimulus(32'h800002B7, 3'd3, 1'b1, 32'h80000000,
                      64'h0000000080000000, 1'b0);
        applyStimulus(32'h000F8073, 3'd5, 1'b0, 32'h0000001F,
                      64'h000000000000001F, 1'b0);
        applyStimulus(32'h800F8073, 3'd5, 1'b0, 32'h0000001F,
                      64'h000000000000001F, 1'b0);
        applyStimulus(32'hFFFFFFFF, 3'd7, 1'b0, 32'h0, 64'h0, 1'b1);
        applyStimulus(32'hFFFFFFFF, 3'd6, 1'b1, 32'h0, 64'h0, 1'b1);
        drain("drain_basic");

        // Backpressure: fill both entries, then issue a third request
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        applyStimulus(32'h00100093, 3'd0, 1'b0, 32'h00000001,
                      64'h0000000000000001, 1'b0);
        applyStimulus(32'h00200093, 3'd0, 1'b0, 32'h00000002,
                      64'h0000000000000002, 1'b0);
        checkOutput("full_count", 64'(count32), 64'd2);
        fork
            begin
                applyStimulus(32'h00300093, 3'd0, 1'b0, 32'h00000003,
                              64'h0000000000000003, 1'b0);
                c_done = 1'b1;
            end
        join_none
        @(negedge clk);
        checkOutput("full_in_ready32", 64'(in_ready32), 64'd0);
        checkOutput("full_in_ready64", 64'(in_ready64), 64'd0);
        checkOutput("full_count64",    64'(count64),    64'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("push_pop_full_count", 64'(count32), 64'd2);
        begin
            int n = 0;
            while (!c_done && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("third_accepted", 64'(c_done), 64'd1);
        drain("drain_backpressure");

        // Reset in the middle of a cycle with two entries buffered
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        applyStimulus(32'h00400093, 3'd0, 1'b0, 32'h00000004,
                      64'h0000000000000004, 1'b0);
        applyStimulus(32'h00500093, 3'd0, 1'b0, 32'h00000005,
                      64'h0000000000000005, 1'b0);
        checkOutput("pre_rst_count", 64'(count32), 64'd2);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid32", 64'(out_valid32), 64'd0);
        checkOutput("mid_rst_count32", 64'(count32),     64'd0);
        checkOutput("mid_rst_valid64", 64'(out_valid64), 64'd0);
        checkOutput("mid_rst_count64", 64'(count64),     64'd0);
        checkOutput("mid_rst_ready",   64'(in_ready32),  64'd0);
        q32.delete();
        q64.delete();
        out_ready = 1'b1;
        #3;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("post_rst_count", 64'(count32),    64'd0);
        checkOutput("post_rst_ready", 64'(in_ready32), 64'd1);

        // The block must still operate normally after the reset
        applyStimulus(32'hFFF00093, 3'd0, 1'b1, 32'h00000FFF,
                      64'h0000000000000FFF, 1'b0);
        drain("drain_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
